score_bcd_serial: RTL and testbench
===================================

# score_bcd_serial

Sequential binary-to-BCD converter between the game score register and the seven-segment digit decoders. It watches the binary score and, whenever the value changes, runs an iterative shift-and-add-3 (double dabble) conversion, one bit per clock. It then atomically updates the decimal digit outputs and pulses `valid`. It replaces a wide combinational converter with a small, timing-friendly serial datapath.

## Interface
Parameters:
- `WIDTH`, 8: binary score width.
- `DIGITS`, 3: number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH − 1. Any other combination is illegal and is not checked in RTL.

Ports:
- `clock`  in  1  system clock (CLOCK_50 domain). Single clock.
- `reset_n`  in  1  synchronous, active-low reset. Sampled on the rising edge of `clock`.
- `score`  in  WIDTH  binary score, unsigned. May change on any cycle.
- `bcd`  out  4*DIGITS  packed digits. `bcd[3:0]` = ones, `bcd[7:4]` = tens, and so on. Each nibble is 0–9.
- `valid`  out  1  one-cycle pulse in the cycle `bcd` takes a new value.
- `busy`  out  1  high while a conversion is in flight (states SHIFT and DONE).
- `blank`  out  DIGITS  leading-zero blank mask, one bit per digit. Bit i = 1 means digit i should be blanked.

## Operation
- Internal registers:
  - `last`: the WIDTH-bit value last accepted for conversion.
  - `sreg`: the shift register, 4*DIGITS + WIDTH bits wide.
  - `cnt`: iteration counter, ceil(log2(WIDTH+1)) bits.
  - `state`: the FSM state.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If `score != last`: load `last <= score`, load `sreg <= {zeros, score}`, set `cnt <= 0`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, once per cycle:
  - For every BCD nibble of `sreg` that is ≥ 5, add 3 to it.
  - Then shift the whole `sreg` left by 1.
  - Increment `cnt`.
  - When the iteration just done is number WIDTH (`cnt == WIDTH-1` before the increment), go to DONE.
- DONE:
  - Load `bcd <=` the upper 4*DIGITS bits of `sreg`.
  - Assert `valid <= 1` for one cycle.
  - Update `blank`.
  - Go to IDLE.
- The add-3 correction works per nibble in 4-bit arithmetic. A nibble in the range 5–9 becomes 8–12, so no carry out of the nibble occurs.
- Score changes while `busy`:
  - Ignored until the FSM returns to IDLE.
  - The IDLE compare against `last` then starts a new conversion automatically.
  - Intermediate values are never lost by skipping: the final displayed value always equals the settled `score`.
- `bcd` holds its last value between conversions. Only DONE writes it.
- `blank[0]` is always 0. For i ≥ 1, `blank[i]` = 1 iff digit i and every higher digit are 0.

## Timing
- Reset values (`reset_n` = 0 at an edge):
  - `state` = IDLE, `bcd` = 0, `valid` = 0, `busy` = 0, `blank` = {DIGITS-1 ones, 0}, `last` = 0, `cnt` = 0.
- A score of 0 after reset therefore starts no conversion.
- Edge E0: IDLE samples `score != last` and captures it.
- Edges E1..E_WIDTH: one iteration per edge.
- Edge E_WIDTH+1: DONE loads the outputs.
- Latency from the capture edge to the `bcd` update is WIDTH+1 cycles (9 for WIDTH=8). `valid` is high for exactly the cycle after E_WIDTH+1.
- `busy` is high from the cycle after E0 through the cycle after E_WIDTH. It is low in the same cycle that `valid` is high.
- Back-to-back conversions:
  - If `score` differs from `last` in the cycle `valid` is high, the next capture happens on that edge.
  - Minimum spacing between `valid` pulses is therefore WIDTH+2 cycles.
- Reset in mid-conversion: the conversion aborts immediately and all reset values apply on that edge. No `valid` is produced for the aborted value.
- Reset has priority over every other event on the same edge.

## Configuration
- `SCORE_BCD_BLANK_EN` defined: the `blank` mask is computed and registered as described under Operation.
- `SCORE_BCD_BLANK_EN` undefined:
  - `blank` is driven constant 0, so all digits are shown, including leading zeros.
  - No blank register is synthesized.
  - All other behaviour is identical.

## Test plan
- Reset, then hold score=0 for 50 cycles → `bcd`=0x000, `valid` never pulses, `busy`=0, `blank`=3'b110.
- Score 0→255 at edge E0 → `bcd`=0x255 appears 9 cycles later with a single `valid` pulse; `busy` is high for exactly 9 cycles.
- Score=37, then score=142 three cycles after capture:
  - First, `bcd`=0x037 with a `valid` pulse.
  - On the next edge the 142 conversion starts.
  - `bcd`=0x142 follows after 9 more cycles (second `valid` pulse).
- Score=200, with `reset_n` low for one cycle five cycles after capture → `bcd`=0x000, no `valid`. After reset releases, 200 is re-captured and yields `bcd`=0x200.
- With `SCORE_BCD_BLANK_EN` defined:
  - score=7 → `blank`=3'b110.
  - score=40 → `blank`=3'b100.
  - score=105 → `blank`=3'b000.
  - Without the macro, all three cases give `blank`=3'b000.
- Exhaustive sweep of score 0..255, each held until `valid` → every `bcd` matches the decimal reference and every nibble is ≤ 9.

Source files
------------

// File: rtl/score_bcd_serial.sv
// Serial binary-to-BCD converter: one double-dabble iteration per clock, restarted whenever the score changes.
// Optional leading-zero blank mask is built only when SCORE_BCD_BLANK_EN is defined; otherwise blank is tied to 0.
module score_bcd_serial #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      score,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  busy,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SR_W  = 4 * DIGITS + WIDTH;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   last;
  logic [SR_W-1:0]    sreg;
  logic [CNT_W-1:0]   cnt;

  // Add 3 to every BCD nibble >= 5, then shift the whole register left by one.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] r;
    r = s;
    for (int d = 0; d < DIGITS; d++) begin
      if (r[WIDTH + 4*d +: 4] >= 4'd5)
        r[WIDTH + 4*d +: 4] = r[WIDTH + 4*d +: 4] + 4'd3;
    end
    return {r[SR_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE:    if (score != last) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The shift register is pure datapath and is always (re)loaded on capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last  <= '0;
      cnt   <= '0;
      bcd   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (score != last) begin
            last <= score;
            sreg <= {{(4*DIGITS){1'b0}}, score};
            cnt  <= '0;
          end
        end
        SHIFT: begin
          sreg <= dabble_step(sreg);
          cnt  <= cnt + CNT_W'(1);
        end
        DONE: begin
          bcd   <= sreg[SR_W-1 -: 4*DIGITS];
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SCORE_BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  // Digit i blanks only when it and every more-significant digit are zero; ones never blanks.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] b);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (b[4*i +: 4] == 4'd0);
      m[i]       = zero_above;
    end
    return m;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n)          blank <= BLANK_RST;
    else if (state == DONE) blank <= blank_mask(sreg[SR_W-1 -: 4*DIGITS]);
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_score_bcd_serial.sv
// Bench for score_bcd_serial: directed and random score changes checked against a decimal-arithmetic model.
// Follows SCORE_BCD_BLANK_EN for the expected blank mask.
module tb_score_bcd_serial;

  localparam int W = 8;
  localparam int D = 3;

  logic             clock;
  logic             reset_n;
  logic [W-1:0]     score;
  logic [4*D-1:0]   bcd;
  logic             valid;
  logic             busy;
  logic [D-1:0]     blank;

  int checks = 0;
  int errors = 0;

  score_bcd_serial #(.WIDTH(W), .DIGITS(D)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .score   (score),
    .bcd     (bcd),
    .valid   (valid),
    .busy    (busy),
    .blank   (blank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ref_bcd(input int v);
    logic [31:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_blank(input int v);
    logic [31:0] m;
    int p;
    m = '0;
`ifdef SCORE_BCD_BLANK_EN
    p = 10;
    for (int i = 1; i < D; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
`else
    p = 0;
    if (p != 0) m = '1;
`endif
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present v, let the next edge capture it, then follow the conversion to its valid pulse.
  task automatic convert(input int v, input bit full);
    int lat;
    int bsy;
    @(posedge clock);
    #1 score = W'(v);
    @(posedge clock);
    lat = -1;
    bsy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (busy) bsy++;
      if (valid) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(W + 1));
    check("bcd", 32'(bcd), ref_bcd(v));
    check("blank", 32'(blank), ref_blank(v));
    for (int d = 0; d < D; d++) check("nibble_le9", 32'(bcd[4*d +: 4] <= 4'd9), 32'd1);
    if (full) begin
      check("busy_cycles", 32'(bsy), 32'(W + 1));
      check("busy_in_valid", 32'(busy), 32'd0);
      @(negedge clock);
      check("valid_single", 32'(valid), 32'd0);
    end
  endtask

  initial begin
    int vcnt;
    int bcnt;
    int k1;
    int k2;
    int prev;
    int v;

    // Reset and idle at zero.
    reset_n = 1'b0;
    score   = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_blank", 32'(blank), ref_blank(0));
    reset_n = 1'b1;
    vcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (valid) vcnt++;
      if (busy) bcnt++;
    end
    check("idle0_valid", 32'(vcnt), 32'd0);
    check("idle0_busy", 32'(bcnt), 32'd0);
    check("idle0_bcd", 32'(bcd), 32'd0);
    check("idle0_blank", 32'(blank), ref_blank(0));

    convert(255, 1'b1);
    convert(7, 1'b1);
    convert(40, 1'b1);
    convert(105, 1'b1);

    // Change score three cycles into a conversion; it must follow right after.
    @(posedge clock);
    #1 score = W'(37);
    @(posedge clock);
    k1 = -1;
    k2 = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (k == 3) score = W'(142);
      if (valid && k1 < 0) begin
        k1 = k;
        check("ovl_bcd37", 32'(bcd), ref_bcd(37));
      end else if (valid) begin
        k2 = k;
        check("ovl_bcd142", 32'(bcd), ref_bcd(142));
        break;
      end
    end
    check("ovl_lat1", 32'(k1), 32'(W + 1));
    check("ovl_spacing", 32'(k2 - k1), 32'(W + 2));

    // Reset five cycles after capturing 200 aborts it; 200 is re-captured afterwards.
    @(posedge clock);
    #1 score = W'(200);
    @(posedge clock);
    k1 = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (k == 4) reset_n = 1'b0;
      if (k == 5) begin
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_blank", 32'(blank), ref_blank(0));
        reset_n = 1'b1;
      end
      if (valid) begin
        k1 = k;
        break;
      end
    end
    check("abort_relat", 32'(k1), 32'(W + 7));
    check("abort_bcd200", 32'(bcd), ref_bcd(200));

    // Random scores.
    prev = 200;
    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 255));
      if (v == prev) v = (v + 1) % 256;
      convert(v, 1'b1);
      prev = v;
    end

    // Exhaustive sweep.
    for (int s = 0; s < 256; s++) begin
      v = (s + 1) % 256;
      if (v == prev) continue;
      convert(v, 1'b0);
      prev = v;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
